// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM states and register-file write-enable codes
// for the iterative multiply/divide unit.
package muldiv_unit_pkg;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_MULH = 2'b01,
    OP_DIVU = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_FULL = 2'b01;
  localparam logic [1:0] WE_MSB  = 2'b10;
  localparam logic [1:0] WE_LSB  = 2'b11;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide, one bit per cycle.
// Shift-add multiply and restoring divide share one hi/lo register pair.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       wa_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       we_out,
  output logic [3:0]       wa_out
);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [3:0]       wa_q, wa_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       wao_q, wao_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH-1:0] diff;

  // hi = product upper half / partial remainder
  // lo = multiplier / quotient
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    wa_d    = wa_q;
    res_d   = res_q;
    wao_d   = wao_q;
    sum     = {1'b0, hi_q} + {1'b0, b_q};
    rem_s   = {hi_q, lo_q[WIDTH-1]};
    diff    = rem_s[WIDTH-1:0] - b_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = CW'(WIDTH - 1);
          op_d    = op;
          b_d     = b;
          wa_d    = wa_in;
          hi_d    = '0;
          lo_d    = a;
        end
      end
      S_RUN: begin
        if (!op_q[1]) begin
          if (lo_q[0]) begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
          end else begin
            hi_d = {1'b0, hi_q[WIDTH-1:1]};
            lo_d = {hi_q[0], lo_q[WIDTH-1:1]};
          end
        end else begin
          if (rem_s >= {1'b0, b_q}) begin
            hi_d = diff;
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_d = rem_s[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          // MULH and REMU live in hi, MUL and DIVU in lo
          res_d   = op_q[0] ? hi_d : lo_d;
          wao_d   = wa_q;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      wa_q    <= '0;
      res_q   <= '0;
      wao_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      wa_q    <= wa_d;
      res_q   <= res_d;
      wao_q   <= wao_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign we_out = done ? WE_FULL : WE_NONE;
  assign result = res_q;
  assign wa_out = wao_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised and directed checks of muldiv_unit against
// a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic [3:0]  wa_in;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [1:0]  we_out;
  logic [3:0]  wa_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .wa_in  (wa_in),
    .busy   (busy),
    .done   (done),
    .result (result),
    .we_out (we_out),
    .wa_out (wa_out)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_model(input logic [1:0] o,
                                            input logic [15:0] x,
                                            input logic [15:0] y);
    logic [31:0] p;
    p = 32'(x) * 32'(y);
    case (o)
      2'b00:   return p[15:0];
      2'b01:   return p[31:16];
      2'b10:   return (y == 0) ? 16'hFFFF : x / y;
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  // Issue one op; optionally disturb inputs and pulse start mid-RUN.
  // Returns at the negedge of the done cycle.
  task automatic do_op(input string tag,
                       input logic [1:0] o,
                       input logic [15:0] x,
                       input logic [15:0] y,
                       input logic [3:0] w,
                       input bit mess);
    int cyc;
    int busy_n;
    int stray;
    bit got_done;
    logic [15:0] exp;
    exp = ref_model(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; wa_in = w; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0; busy_n = 0; stray = 0; got_done = 0;
    while (cyc < 40 && !got_done) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_n++;
      if (done) got_done = 1;
      else if (we_out != 2'b00) stray++;
      if (mess && cyc == 3) begin
        a = ~x; b = y + 16'd3; op = o ^ 2'b01;
        wa_in = ~w; start = 1'b1;
      end
      if (mess && cyc == 5) start = 1'b0;
    end
    check({tag, ".done"}, 32'(got_done), 32'd1);
    check({tag, ".lat"}, 32'(cyc), 32'd17);
    check({tag, ".busy"}, 32'(busy_n), 32'd16);
    check({tag, ".stray_we"}, 32'(stray), 32'd0);
    check({tag, ".res"}, 32'(result), 32'(exp));
    check({tag, ".we"}, 32'(we_out), 32'd1);
    check({tag, ".wa"}, 32'(wa_out), 32'(w));
  endtask

  initial begin
    int cyc;
    int seen;
    logic [15:0] held;
    rst = 1'b1; start = 1'b0; op = 2'b00;
    a = '0; b = '0; wa_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.res", 32'(result), 32'd0);
    check("rst.we", 32'(we_out), 32'd0);
    check("rst.wa", 32'(wa_out), 32'd0);

    do_op("mul", 2'b00, 16'h1234, 16'h0010, 4'd5, 0);
    check("mul.val", 32'(result), 32'h2340);
    do_op("mulh", 2'b01, 16'h1234, 16'h0010, 4'd6, 0);
    check("mulh.val", 32'(result), 32'h0001);
    do_op("mulw", 2'b00, 16'hFFFF, 16'hFFFF, 4'd1, 0);
    check("mulw.val", 32'(result), 32'h0001);
    do_op("mulhw", 2'b01, 16'hFFFF, 16'hFFFF, 4'd2, 0);
    check("mulhw.val", 32'(result), 32'hFFFE);
    do_op("div", 2'b10, 16'd100, 16'd7, 4'd3, 0);
    check("div.val", 32'(result), 32'h000E);
    do_op("rem", 2'b11, 16'd100, 16'd7, 4'd4, 0);
    check("rem.val", 32'(result), 32'h0002);
    do_op("divs", 2'b10, 16'h0005, 16'h0009, 4'd7, 0);
    check("divs.val", 32'(result), 32'h0000);
    do_op("rems", 2'b11, 16'h0005, 16'h0009, 4'd8, 0);
    check("rems.val", 32'(result), 32'h0005);
    do_op("div0", 2'b10, 16'h1234, 16'h0000, 4'd9, 0);
    check("div0.val", 32'(result), 32'hFFFF);
    do_op("rem0", 2'b11, 16'h1234, 16'h0000, 4'd10, 0);
    check("rem0.val", 32'(result), 32'h1234);
    do_op("mess", 2'b00, 16'h00AB, 16'h0102, 4'd11, 1);

    // result and wa_out hold after done
    held = result;
    repeat (3) @(negedge clk);
    check("hold.res", 32'(result), 32'(held));
    check("hold.wa", 32'(wa_out), 32'd11);
    check("hold.done", 32'(done), 32'd0);

    // back-to-back pairs follow directly inside do_op
    do_op("b2b0", 2'b10, 16'hBEEF, 16'h0013, 4'd12, 0);
    do_op("b2b1", 2'b01, 16'hBEEF, 16'h0013, 4'd13, 0);

    // reset in RUN cycle 8
    @(negedge clk);
    op = 2'b00; a = 16'h7777; b = 16'h0009; wa_in = 4'd14; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mrst.busy", 32'(busy), 32'd0);
    check("mrst.res", 32'(result), 32'd0);
    check("mrst.we", 32'(we_out), 32'd0);
    check("mrst.wa", 32'(wa_out), 32'd0);
    seen = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (done || we_out != 2'b00) seen++;
    end
    check("mrst.nodone", 32'(seen), 32'd0);
    do_op("post", 2'b00, 16'd3, 16'd4, 4'd15, 0);
    check("post.val", 32'(result), 32'h000C);

    for (int i = 0; i < 40; i++) begin
      logic [1:0]  ro;
      logic [15:0] rx;
      logic [15:0] ry;
      ro = 2'($urandom_range(0, 3));
      rx = 16'($urandom);
      ry = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ry = 16'h0000;
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      do_op("rnd", ro, rx, ry, 4'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
